// File: rtl/ld_st_buffer.sv
// ============================================================================
// Module   : ld_st_buffer
// Purpose  : In-order load/store buffer; snoops the CDB for operands and
//            issues the head entry as a registered single-cycle request.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ld_st_buffer #(
    parameter int DEPTH   = 4,
    parameter int ROBEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic                     alloc_is_store,
    input  logic [ROBEN_W-1:0]       alloc_ROBEN,
    input  logic [ROBEN_W-1:0]       alloc_ROBEN1,
    input  logic [31:0]              alloc_ROBEN1_VAL,
    input  logic [ROBEN_W-1:0]       alloc_ROBEN2,
    input  logic [31:0]              alloc_ROBEN2_VAL,
    input  logic [31:0]              alloc_Immediate,
    input  logic                     CDB_valid,
    input  logic [ROBEN_W-1:0]       CDB_ROBEN,
    input  logic [31:0]              CDB_Write_Data,
    input  logic [ROBEN_W-1:0]       commit_store_ROBEN,
    input  logic                     flush,
    output logic                     LdStB_FULL,
    output logic [$clog2(DEPTH):0]   LdStB_count,
    output logic [ROBEN_W-1:0]       LdStB_MEMU_ROBEN,
    output logic                     LdStB_MEMU_Read_en,
    output logic                     LdStB_MEMU_Write_en,
    output logic [31:0]              LdStB_MEMU_ROBEN1_VAL,
    output logic [31:0]              LdStB_MEMU_Immediate,
    output logic [31:0]              LdStB_MEMU_address,
    output logic [31:0]              LdStB_MEMU_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   st_q, st_d;
    logic [ROBEN_W-1:0] rob_q [DEPTH];
    logic [ROBEN_W-1:0] rob_d [DEPTH];
    logic [ROBEN_W-1:0] t1_q  [DEPTH];
    logic [ROBEN_W-1:0] t1_d  [DEPTH];
    logic [31:0]        v1_q  [DEPTH];
    logic [31:0]        v1_d  [DEPTH];
    logic [ROBEN_W-1:0] t2_q  [DEPTH];
    logic [ROBEN_W-1:0] t2_d  [DEPTH];
    logic [31:0]        v2_q  [DEPTH];
    logic [31:0]        v2_d  [DEPTH];
    logic [31:0]        imm_q [DEPTH];
    logic [31:0]        imm_d [DEPTH];

    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ROBEN_W-1:0] o_rob_q, o_rob_d;
    logic               o_rd_q, o_rd_d, o_wr_q, o_wr_d;
    logic [31:0]        o_v1_q, o_v1_d, o_imm_q, o_imm_d;
    logic [31:0]        o_addr_q, o_addr_d, o_data_q, o_data_d;

    logic w_full, w_alloc, w_issue, w_byp1, w_byp2;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_alloc = alloc_valid && !w_full && !flush;
    // Issue looks only at registered entry state; same-cycle CDB data is not forwarded.
    assign w_issue = !flush && valid_q[head_q] && (t1_q[head_q] == '0) &&
                     (!st_q[head_q] ||
                      ((t2_q[head_q] == '0) && (commit_store_ROBEN == rob_q[head_q])));
    assign w_byp1  = CDB_valid && (alloc_ROBEN1 != '0) && (CDB_ROBEN == alloc_ROBEN1);
    assign w_byp2  = CDB_valid && (alloc_ROBEN2 != '0) && (CDB_ROBEN == alloc_ROBEN2);

    always_comb begin
        valid_d  = valid_q;
        st_d     = st_q;
        rob_d    = rob_q;
        t1_d     = t1_q;
        v1_d     = v1_q;
        t2_d     = t2_q;
        v2_d     = v2_q;
        imm_d    = imm_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        o_rob_d  = o_rob_q;
        o_v1_d   = o_v1_q;
        o_imm_d  = o_imm_q;
        o_addr_d = o_addr_q;
        o_data_d = o_data_q;
        o_rd_d   = 1'b0;
        o_wr_d   = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && CDB_valid) begin
                if ((t1_q[i] != '0) && (t1_q[i] == CDB_ROBEN)) begin
                    t1_d[i] = '0;
                    v1_d[i] = CDB_Write_Data;
                end
                if ((t2_q[i] != '0) && (t2_q[i] == CDB_ROBEN)) begin
                    t2_d[i] = '0;
                    v2_d[i] = CDB_Write_Data;
                end
            end
        end

        if (w_issue) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            o_rd_d          = !st_q[head_q];
            o_wr_d          = st_q[head_q];
            o_rob_d         = rob_q[head_q];
            o_v1_d          = v1_q[head_q];
            o_imm_d         = imm_q[head_q];
            o_addr_d        = v1_q[head_q] + imm_q[head_q];
            o_data_d        = st_q[head_q] ? v2_q[head_q] : 32'd0;
        end

        if (w_alloc) begin
            valid_d[tail_q] = 1'b1;
            st_d[tail_q]    = alloc_is_store;
            rob_d[tail_q]   = alloc_ROBEN;
            t1_d[tail_q]    = w_byp1 ? '0 : alloc_ROBEN1;
            v1_d[tail_q]    = w_byp1 ? CDB_Write_Data : alloc_ROBEN1_VAL;
            t2_d[tail_q]    = w_byp2 ? '0 : alloc_ROBEN2;
            v2_d[tail_q]    = w_byp2 ? CDB_Write_Data : alloc_ROBEN2_VAL;
            imm_d[tail_q]   = alloc_Immediate;
            tail_d          = tail_q + PTR_W'(1);
        end

        case ({w_alloc, w_issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q  <= '0;
            st_q     <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            o_rob_q  <= '0;
            o_rd_q   <= 1'b0;
            o_wr_q   <= 1'b0;
            o_v1_q   <= '0;
            o_imm_q  <= '0;
            o_addr_q <= '0;
            o_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
                t1_q[i]  <= '0;
                v1_q[i]  <= '0;
                t2_q[i]  <= '0;
                v2_q[i]  <= '0;
                imm_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            st_q     <= st_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            o_rob_q  <= o_rob_d;
            o_rd_q   <= o_rd_d;
            o_wr_q   <= o_wr_d;
            o_v1_q   <= o_v1_d;
            o_imm_q  <= o_imm_d;
            o_addr_q <= o_addr_d;
            o_data_q <= o_data_d;
            rob_q    <= rob_d;
            t1_q     <= t1_d;
            v1_q     <= v1_d;
            t2_q     <= t2_d;
            v2_q     <= v2_d;
            imm_q    <= imm_d;
        end
    end

    assign LdStB_FULL            = w_full;
    assign LdStB_count           = count_q;
    assign LdStB_MEMU_ROBEN      = o_rob_q;
    assign LdStB_MEMU_Read_en    = o_rd_q;
    assign LdStB_MEMU_Write_en   = o_wr_q;
    assign LdStB_MEMU_ROBEN1_VAL = o_v1_q;
    assign LdStB_MEMU_Immediate  = o_imm_q;
    assign LdStB_MEMU_address    = o_addr_q;
    assign LdStB_MEMU_data       = o_data_q;

endmodule

`default_nettype wire

// File: tb/tb_ld_st_buffer.sv
// ============================================================================
// Module   : tb_ld_st_buffer
// Purpose  : Directed vector table plus random traffic against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ld_st_buffer;

    localparam int DEPTH = 4;

    logic        clk, rst_n;
    logic        alloc_valid, alloc_is_store, CDB_valid, flush;
    logic [3:0]  alloc_ROBEN, alloc_ROBEN1, alloc_ROBEN2, CDB_ROBEN, commit_store_ROBEN;
    logic [31:0] alloc_ROBEN1_VAL, alloc_ROBEN2_VAL, alloc_Immediate, CDB_Write_Data;
    logic        LdStB_FULL, rd_en, wr_en;
    logic [2:0]  LdStB_count;
    logic [3:0]  m_rob;
    logic [31:0] m_v1, m_imm, m_addr, m_data;

    ld_st_buffer #(.DEPTH(DEPTH), .ROBEN_W(4)) dut (
        .clk(clk), .rst(rst_n),
        .alloc_valid(alloc_valid), .alloc_is_store(alloc_is_store),
        .alloc_ROBEN(alloc_ROBEN), .alloc_ROBEN1(alloc_ROBEN1),
        .alloc_ROBEN1_VAL(alloc_ROBEN1_VAL), .alloc_ROBEN2(alloc_ROBEN2),
        .alloc_ROBEN2_VAL(alloc_ROBEN2_VAL), .alloc_Immediate(alloc_Immediate),
        .CDB_valid(CDB_valid), .CDB_ROBEN(CDB_ROBEN), .CDB_Write_Data(CDB_Write_Data),
        .commit_store_ROBEN(commit_store_ROBEN), .flush(flush),
        .LdStB_FULL(LdStB_FULL), .LdStB_count(LdStB_count),
        .LdStB_MEMU_ROBEN(m_rob), .LdStB_MEMU_Read_en(rd_en),
        .LdStB_MEMU_Write_en(wr_en), .LdStB_MEMU_ROBEN1_VAL(m_v1),
        .LdStB_MEMU_Immediate(m_imm), .LdStB_MEMU_address(m_addr),
        .LdStB_MEMU_data(m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic av, st; logic [3:0] rob, r1; logic [31:0] v1; logic [3:0] r2;
        logic [31:0] v2, imm; logic cv; logic [3:0] ctag; logic [31:0] cdata;
        logic [3:0] commit; logic fl;
        logic erd, ewr; logic [3:0] erob; logic [31:0] eaddr, edata;
        logic [2:0] ecnt; logic efull;
    } vec_t;

    typedef struct {
        logic st; logic [3:0] rob, t1; logic [31:0] v1; logic [3:0] t2; logic [31:0] v2, imm;
    } ent_t;

    ent_t q[$];
    vec_t tbl[31];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic av, logic st, logic [3:0] rob, logic [3:0] r1,
        logic [31:0] v1, logic [3:0] r2, logic [31:0] v2, logic [31:0] imm, logic cv,
        logic [3:0] ctag, logic [31:0] cdata, logic [3:0] commit, logic fl, logic erd,
        logic ewr, logic [3:0] erob, logic [31:0] eaddr, logic [31:0] edata,
        logic [2:0] ecnt, logic efull);
        vec_t v;
        v.av = av; v.st = st; v.rob = rob; v.r1 = r1; v.v1 = v1; v.r2 = r2; v.v2 = v2;
        v.imm = imm; v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.commit = commit; v.fl = fl;
        v.erd = erd; v.ewr = ewr; v.erob = erob; v.eaddr = eaddr; v.edata = edata;
        v.ecnt = ecnt; v.efull = efull;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input vec_t v);
        alloc_valid = v.av; alloc_is_store = v.st; alloc_ROBEN = v.rob;
        alloc_ROBEN1 = v.r1; alloc_ROBEN1_VAL = v.v1; alloc_ROBEN2 = v.r2;
        alloc_ROBEN2_VAL = v.v2; alloc_Immediate = v.imm; CDB_valid = v.cv;
        CDB_ROBEN = v.ctag; CDB_Write_Data = v.cdata; commit_store_ROBEN = v.commit;
        flush = v.fl;
    endtask

    // Advances one edge, then moves the queue model and compares every output.
    task automatic tick();
        ent_t h, n;
        bit   iss;
        int   n_before;
        @(posedge clk);
        #1;
        iss = 0;
        h = '{default: '0};
        if (flush) begin
            q.delete();
        end else begin
            n_before = q.size();
            if (n_before > 0) begin
                h = q[0];
                iss = (h.t1 == 0) && (!h.st || (h.t2 == 0 && commit_store_ROBEN == h.rob));
            end
            if (iss) void'(q.pop_front());
            foreach (q[i]) begin
                if (CDB_valid && q[i].t1 != 0 && q[i].t1 == CDB_ROBEN) begin
                    q[i].t1 = 0; q[i].v1 = CDB_Write_Data;
                end
                if (CDB_valid && q[i].t2 != 0 && q[i].t2 == CDB_ROBEN) begin
                    q[i].t2 = 0; q[i].v2 = CDB_Write_Data;
                end
            end
            if (alloc_valid && n_before < DEPTH) begin
                n.st = alloc_is_store; n.rob = alloc_ROBEN; n.imm = alloc_Immediate;
                n.t1 = alloc_ROBEN1; n.v1 = alloc_ROBEN1_VAL;
                n.t2 = alloc_ROBEN2; n.v2 = alloc_ROBEN2_VAL;
                if (CDB_valid && n.t1 != 0 && n.t1 == CDB_ROBEN) begin
                    n.t1 = 0; n.v1 = CDB_Write_Data;
                end
                if (CDB_valid && n.t2 != 0 && n.t2 == CDB_ROBEN) begin
                    n.t2 = 0; n.v2 = CDB_Write_Data;
                end
                q.push_back(n);
            end
        end
        chk("model.read_en", rd_en, iss && !h.st);
        chk("model.write_en", wr_en, iss && h.st);
        chk("model.count", LdStB_count, q.size());
        chk("model.full", LdStB_FULL, q.size() == DEPTH);
        if (iss) begin
            chk("model.roben", m_rob, h.rob);
            chk("model.address", m_addr, h.v1 + h.imm);
            chk("model.data", m_data, h.st ? h.v2 : 32'd0);
            chk("model.roben1_val", m_v1, h.v1);
            chk("model.immediate", m_imm, h.imm);
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

        //        av st rob r1 v1          r2 v2          imm          cv ct cdata       cm fl  rd wr rob addr         data        cnt full
        tbl[0]  = mk(1,0,1, 0, 32'd100,    0, 0,          32'd4,       0,0, 0,          0, 0,  0,0,0, 0,           0,          1,0);
        tbl[1]  = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  1,0,1, 32'd104,     0,          0,0);
        tbl[2]  = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          0,0);
        tbl[3]  = mk(1,1,3, 0, 32'h200,    5, 0,          32'd8,       0,0, 0,          0, 0,  0,0,0, 0,           0,          1,0);
        tbl[4]  = mk(0,0,0, 0, 0,          0, 0,          0,           1,5, 32'hDEAD,   3, 0,  0,0,0, 0,           0,          1,0);
        tbl[5]  = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          1,0);
        tbl[6]  = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          3, 0,  0,1,3, 32'h208,     32'hDEAD,   0,0);
        tbl[7]  = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          0,0);
        tbl[8]  = mk(1,0,4, 7, 0,          0, 0,          32'hFFFFFFFC,0,0, 0,          0, 0,  0,0,0, 0,           0,          1,0);
        tbl[9]  = mk(1,0,6, 0, 32'h40,     0, 0,          0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          2,0);
        tbl[10] = mk(0,0,0, 0, 0,          0, 0,          0,           1,7, 32'h10,     0, 0,  0,0,0, 0,           0,          2,0);
        tbl[11] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  1,0,4, 32'h0C,      0,          1,0);
        tbl[12] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  1,0,6, 32'h40,      0,          0,0);
        tbl[13] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          0,0);
        tbl[14] = mk(1,0,2, 9, 0,          0, 0,          32'd1,       1,9, 32'h50,     0, 0,  0,0,0, 0,           0,          1,0);
        tbl[15] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  1,0,2, 32'h51,      0,          0,0);
        tbl[16] = mk(1,1,8, 0, 32'h1000,   0, 32'd8,      0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          1,0);
        tbl[17] = mk(1,1,9, 0, 32'h1000,   0, 32'd9,      0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          2,0);
        tbl[18] = mk(1,1,10,0, 32'h1000,   0, 32'd10,     0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          3,0);
        tbl[19] = mk(1,1,11,0, 32'h1000,   0, 32'd11,     0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          4,1);
        tbl[20] = mk(1,0,12,0, 32'h1,      0, 0,          0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          4,1);
        tbl[21] = mk(1,0,13,0, 32'h1,      0, 0,          0,           0,0, 0,          8, 0,  0,1,8, 32'h1000,    32'd8,      3,0);
        tbl[22] = mk(1,0,14,0, 32'h1000,   0, 0,          0,           0,0, 0,          9, 0,  0,1,9, 32'h1000,    32'd9,      3,0);
        tbl[23] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          10,0,  0,1,10,32'h1000,    32'd10,     2,0);
        tbl[24] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          11,0,  0,1,11,32'h1000,    32'd11,     1,0);
        tbl[25] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          0, 0,  1,0,14,32'h1000,    0,          0,0);
        tbl[26] = mk(1,1,1, 0, 32'h20,     0, 32'h77,     0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          1,0);
        tbl[27] = mk(1,1,2, 0, 32'h20,     0, 32'h77,     0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          2,0);
        tbl[28] = mk(1,1,3, 0, 32'h20,     0, 32'h77,     0,           0,0, 0,          0, 0,  0,0,0, 0,           0,          3,0);
        tbl[29] = mk(1,0,4, 0, 32'h20,     0, 0,          0,           0,0, 0,          1, 1,  0,0,0, 0,           0,          0,0);
        tbl[30] = mk(0,0,0, 0, 0,          0, 0,          0,           0,0, 0,          1, 0,  0,0,0, 0,           0,          0,0);

        rst_n = 1'b0;
        set_in(idle);
        repeat (2) @(posedge clk);
        #1;
        chk("reset.count", LdStB_count, 0);
        chk("reset.full", LdStB_FULL, 0);
        chk("reset.read_en", rd_en, 0);
        chk("reset.write_en", wr_en, 0);
        chk("reset.roben", m_rob, 0);
        chk("reset.address", m_addr, 0);
        chk("reset.data", m_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            set_in(tbl[i]);
            tick();
            chk($sformatf("vec%0d.read_en", i), rd_en, tbl[i].erd);
            chk($sformatf("vec%0d.write_en", i), wr_en, tbl[i].ewr);
            chk($sformatf("vec%0d.count", i), LdStB_count, tbl[i].ecnt);
            chk($sformatf("vec%0d.full", i), LdStB_FULL, tbl[i].efull);
            if (tbl[i].erd || tbl[i].ewr) begin
                chk($sformatf("vec%0d.roben", i), m_rob, tbl[i].erob);
                chk($sformatf("vec%0d.address", i), m_addr, tbl[i].eaddr);
                chk($sformatf("vec%0d.data", i), m_data, tbl[i].edata);
            end
        end

        // Asynchronous reset while a load request is on the bus.
        set_in(mk(1,0,5,0,32'h300,0,0,32'd4,0,0,0,0,0, 0,0,0,0,0,0,0));
        tick();
        set_in(mk(1,0,6,0,32'h400,0,0,32'd4,0,0,0,0,0, 0,0,0,0,0,0,0));
        tick();
        chk("arst.pre_read_en", rd_en, 1);
        set_in(idle);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.read_en", rd_en, 0);
        chk("arst.count", LdStB_count, 0);
        chk("arst.roben", m_rob, 0);
        chk("arst.address", m_addr, 0);
        chk("arst.roben1_val", m_v1, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        for (int c = 0; c < 2000; c++) begin
            vec_t r;
            r = idle;
            r.av    = $urandom_range(0, 1);
            r.st    = $urandom_range(0, 1);
            r.rob   = 4'($urandom_range(1, 15));
            r.r1    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            r.v1    = $urandom;
            r.r2    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            r.v2    = $urandom;
            r.imm   = $urandom;
            r.cv    = $urandom_range(0, 1);
            r.ctag  = 4'($urandom_range(1, 15));
            r.cdata = $urandom;
            r.commit = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[0].rob
                                                                   : 4'($urandom_range(0, 15));
            r.fl    = ($urandom_range(0, 59) == 0);
            set_in(r);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
